branch_resolve_stage: RTL and testbench

Execute-side half of the fetch/redirect handshake. Accepts the instruction stream the fetch stage emits (real instructions plus NOOP bubbles), reads branch/JAL operands from the register file, and evaluates the branch condition. Returns the registered redirect bundle (`execStageCmp`, `execStageImm`, `execStageRs1`) exactly in the cycle fetch's two-cycle branch-wait counter reaches its PC-write slot. It also flags any violation of the bubble protocol.

---
 rtl/branch_resolve_stage_pkg.sv | 38 +++
 rtl/branch_resolve_stage_cond.sv | 46 ++++
 rtl/branch_resolve_stage.sv | 138 +++++++++++++
 tb/tb_branch_resolve_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_stage_pkg.sv
// Shared decode constants and FSM encoding for the execute-side branch resolver.
package branch_resolve_stage_pkg;

  localparam logic [31:0] NOOP_WORD = 32'h3b000099;

  localparam logic [3:0] OP_BRANCH = 4'h6;
  localparam logic [3:0] OP_JAL    = 4'hB;

  // Field positions within the instruction word
  localparam int unsigned FUNC_LSB    = 28;
  localparam int unsigned OPC_LSB     = 24;
  localparam int unsigned BR_RS1_LSB  = 20;
  localparam int unsigned BR_RS2_LSB  = 16;
  localparam int unsigned JAL_RS1_LSB = 16;
  localparam int unsigned IMM_LSB     = 0;

  localparam logic [3:0] FN_F    = 4'h0;
  localparam logic [3:0] FN_EQ   = 4'h1;
  localparam logic [3:0] FN_LT   = 4'h2;
  localparam logic [3:0] FN_LTE  = 4'h3;
  localparam logic [3:0] FN_EQZ  = 4'h5;
  localparam logic [3:0] FN_LTZ  = 4'h6;
  localparam logic [3:0] FN_LTEZ = 4'h7;
  localparam logic [3:0] FN_T    = 4'h8;
  localparam logic [3:0] FN_NE   = 4'h9;
  localparam logic [3:0] FN_GTE  = 4'hA;
  localparam logic [3:0] FN_GT   = 4'hB;
  localparam logic [3:0] FN_NEZ  = 4'hD;
  localparam logic [3:0] FN_GTEZ = 4'hE;
  localparam logic [3:0] FN_GTZ  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_RESOLVE = 2'd2
  } brs_state_t;

endpackage

// File: rtl/branch_resolve_stage_cond.sv
// branch_cond_eval: combinational signed branch-condition evaluator with illegal-func flag.
module branch_cond_eval
  import branch_resolve_stage_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic [3:0]       i_func,
  input  logic [DBITS-1:0] i_a,
  input  logic [DBITS-1:0] i_b,
  output logic             o_taken,
  output logic             o_illegal
);

  logic w_a_neg;
  logic w_a_zero;
  logic w_eq;
  logic w_lt;

  assign w_a_neg  = i_a[DBITS-1];
  assign w_a_zero = (i_a == '0);
  assign w_eq     = (i_a == i_b);
  assign w_lt     = ($signed(i_a) < $signed(i_b));

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_func)
      FN_F:    o_taken = 1'b0;
      FN_EQ:   o_taken = w_eq;
      FN_LT:   o_taken = w_lt;
      FN_LTE:  o_taken = w_lt | w_eq;
      FN_T:    o_taken = 1'b1;
      FN_NE:   o_taken = ~w_eq;
      FN_GTE:  o_taken = ~w_lt;
      FN_GT:   o_taken = ~w_lt & ~w_eq;
      FN_EQZ:  o_taken = w_a_zero;
      FN_LTZ:  o_taken = w_a_neg;
      FN_LTEZ: o_taken = w_a_neg | w_a_zero;
      FN_NEZ:  o_taken = ~w_a_zero;
      FN_GTEZ: o_taken = ~w_a_neg;
      FN_GTZ:  o_taken = ~w_a_neg & ~w_a_zero;
      default: o_illegal = 1'b1;  // funcs 4 and C
    endcase
  end

endmodule

// File: rtl/branch_resolve_stage.sv
// Execute-side branch/JAL resolver: IDLE -> OPERAND -> RESOLVE, redirect valid in RESOLVE.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken BRANCH counters.
module branch_resolve_stage
  import branch_resolve_stage_pkg::*;
#(
  parameter int DBITS  = 32,
  parameter int REGIDX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  instruction,
  input  logic [DBITS-1:0]  pc,
  output logic [REGIDX-1:0] rs1Idx,
  output logic [REGIDX-1:0] rs2Idx,
  input  logic [DBITS-1:0]  rs1Data,
  input  logic [DBITS-1:0]  rs2Data,
  output logic              execStageCmp,
  output logic [DBITS-1:0]  execStageImm,
  output logic [DBITS-1:0]  execStageRs1,
  output logic              redirectValid,
  output logic              protocolError
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       takenCount,
  output logic [15:0]       notTakenCount
`endif
);

  brs_state_t r_state;
  brs_state_t w_next;

  logic [31:0]      r_instr;
  logic             r_cmp;
  logic [DBITS-1:0] r_imm;
  logic [DBITS-1:0] r_rs1;
  logic             r_perr;

  logic       w_is_noop;
  logic [3:0] w_in_op;
  logic       w_capture;
  logic       w_lat_branch;
  logic       w_taken;
  logic       w_illegal;
  logic       w_unused_pc;

  assign w_unused_pc  = ^pc;
  assign w_is_noop    = (instruction[31:0] == NOOP_WORD);
  assign w_in_op      = instruction[OPC_LSB +: 4];
  // NOOP shares the JAL opcode, so the full-word match gates capture
  assign w_capture    = (r_state == ST_IDLE) && !w_is_noop &&
                        ((w_in_op == OP_BRANCH) || (w_in_op == OP_JAL));
  assign w_lat_branch = (r_instr[OPC_LSB +: 4] == OP_BRANCH);

  branch_cond_eval #(
    .DBITS (DBITS)
  ) u_cond (
    .i_func    (r_instr[FUNC_LSB +: 4]),
    .i_a       (rs1Data),
    .i_b       (rs2Data),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_next = r_state;
    rs1Idx = '0;
    rs2Idx = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) w_next = ST_OPERAND;
      end
      ST_OPERAND: begin
        w_next = ST_RESOLVE;
        if (w_lat_branch) begin
          rs1Idx = REGIDX'(r_instr[BR_RS1_LSB +: 4]);
          rs2Idx = REGIDX'(r_instr[BR_RS2_LSB +: 4]);
        end else begin
          rs1Idx = REGIDX'(r_instr[JAL_RS1_LSB +: 4]);
        end
      end
      ST_RESOLVE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
      r_cmp   <= 1'b0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_perr  <= 1'b0;
    end else begin
      if (w_capture) r_instr <= instruction[31:0];
      if (r_state == ST_OPERAND) begin
        r_cmp <= w_lat_branch ? w_taken : 1'b1;
        r_imm <= {{(DBITS-18){r_instr[IMM_LSB+15]}}, r_instr[IMM_LSB +: 16], 2'b00};
        r_rs1 <= rs1Data;
        if (w_lat_branch && w_illegal) r_perr <= 1'b1;
      end
      if (((r_state == ST_OPERAND) || (r_state == ST_RESOLVE)) && !w_is_noop)
        r_perr <= 1'b1;
    end
  end

  assign execStageCmp  = r_cmp;
  assign execStageImm  = r_imm;
  assign execStageRs1  = r_rs1;
  assign redirectValid = (r_state == ST_RESOLVE);
  assign protocolError = r_perr;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_ntaken_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken_cnt  <= '0;
      r_ntaken_cnt <= '0;
    end else if ((r_state == ST_RESOLVE) && w_lat_branch) begin
      if (r_cmp) begin
        if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 16'd1;
      end else begin
        if (r_ntaken_cnt != '1) r_ntaken_cnt <= r_ntaken_cnt + 16'd1;
      end
    end
  end

  assign takenCount    = r_taken_cnt;
  assign notTakenCount = r_ntaken_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed self-checking bench for branch_resolve_stage (BRANCH_STATS_EN optional).
module tb_branch_resolve_stage;

  localparam logic [31:0] NOOP = 32'h3b000099;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [3:0]  rs1Idx;
  logic [3:0]  rs2Idx;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        execStageCmp;
  logic [31:0] execStageImm;
  logic [31:0] execStageRs1;
  logic        redirectValid;
  logic        protocolError;
`ifdef BRANCH_STATS_EN
  logic [15:0] takenCount;
  logic [15:0] notTakenCount;
`endif

  logic [31:0] regs [16];
  int n_checks;
  int n_errors;

  assign rs1Data = regs[rs1Idx];
  assign rs2Data = regs[rs2Idx];

  branch_resolve_stage #(
    .DBITS  (32),
    .REGIDX (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .instruction   (instruction),
    .pc            (pc),
    .rs1Idx        (rs1Idx),
    .rs2Idx        (rs2Idx),
    .rs1Data       (rs1Data),
    .rs2Data       (rs2Data),
    .execStageCmp  (execStageCmp),
    .execStageImm  (execStageImm),
    .execStageRs1  (execStageRs1),
    .redirectValid (redirectValid),
    .protocolError (protocolError)
`ifdef BRANCH_STATS_EN
    ,
    .takenCount    (takenCount),
    .notTakenCount (notTakenCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_br(input logic [3:0] fn, input logic [3:0] a,
                                        input logic [3:0] b, input logic [15:0] imm);
    return {fn, 4'h6, a, b, imm};
  endfunction

  function automatic logic [31:0] mk_jal(input logic [3:0] a, input logic [15:0] imm);
    return {4'h0, 4'hB, 4'h0, a, imm};
  endfunction

  // present instr in T, follow word in T+1, check OPERAND indices and RESOLVE outputs
  task automatic do_branch(input string tag, input logic [31:0] instr, input logic [31:0] follow,
                           input logic [3:0] ei1, input logic [3:0] ei2, input logic ecmp,
                           input logic [31:0] eimm, input logic [31:0] ers1);
    instruction = instr;
    tick();
    instruction = follow;
    check({tag, ".rs1Idx"}, 32'(rs1Idx), 32'(ei1));
    check({tag, ".rs2Idx"}, 32'(rs2Idx), 32'(ei2));
    check({tag, ".rv_T1"}, 32'(redirectValid), 32'd0);
    tick();
    instruction = NOOP;
    check({tag, ".rv_T2"}, 32'(redirectValid), 32'd1);
    check({tag, ".cmp"}, 32'(execStageCmp), 32'(ecmp));
    check({tag, ".imm"}, execStageImm, eimm);
    check({tag, ".rs1"}, execStageRs1, ers1);
    tick();
    check({tag, ".rv_T3"}, 32'(redirectValid), 32'd0);
    check({tag, ".idx_idle"}, 32'(rs1Idx), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    reset = 1'b1;
    instruction = NOOP;
    pc = 32'h0000_1000;
    repeat (2) @(posedge clk);
    #1;
    check("rst.cmp", 32'(execStageCmp), 32'd0);
    check("rst.imm", execStageImm, 32'd0);
    check("rst.rs1", execStageRs1, 32'd0);
    check("rst.rv", 32'(redirectValid), 32'd0);
    check("rst.perr", 32'(protocolError), 32'd0);
    check("rst.rs1Idx", 32'(rs1Idx), 32'd0);
    check("rst.rs2Idx", 32'(rs2Idx), 32'd0);
    reset = 1'b0;
    tick();

    regs[1] = 32'd5;
    regs[2] = 32'd5;
    do_branch("beq", mk_br(4'h1, 4'd1, 4'd2, 16'h0003), NOOP, 4'd1, 4'd2, 1'b1, 32'h0000000C, 32'd5);

    regs[3] = 32'hFFFFFFFF;
    regs[4] = 32'h0;
    do_branch("blt_t", mk_br(4'h2, 4'd3, 4'd4, 16'hFFFF), NOOP, 4'd3, 4'd4, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF);
    regs[3] = 32'd1;
    do_branch("blt_n", mk_br(4'h2, 4'd3, 4'd4, 16'hFFFF), NOOP, 4'd3, 4'd4, 1'b0, 32'hFFFFFFFC, 32'd1);

    regs[7] = 32'h00000100;
    do_branch("jal", mk_jal(4'd7, 16'h0010), NOOP, 4'd7, 4'd0, 1'b1, 32'h00000040, 32'h00000100);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("noop.rv", 32'(redirectValid), 32'd0);
      check("noop.idx", 32'(rs1Idx), 32'd0);
    end
    check("noop.hold_cmp", 32'(execStageCmp), 32'd1);
    check("noop.hold_rs1", execStageRs1, 32'h00000100);

    regs[5] = 32'hFFFFFFFF;
    regs[6] = 32'd1;
    do_branch("bgt", mk_br(4'hB, 4'd5, 4'd6, 16'h0002), NOOP, 4'd5, 4'd6, 1'b0, 32'h00000008, 32'hFFFFFFFF);
    do_branch("bnez", mk_br(4'hD, 4'd1, 4'd0, 16'h7FFF), NOOP, 4'd1, 4'd0, 1'b1, 32'h0001FFFC, 32'd5);
    do_branch("bgtz", mk_br(4'hF, 4'd4, 4'd0, 16'h8000), NOOP, 4'd4, 4'd0, 1'b0, 32'hFFFE0000, 32'd0);
    do_branch("bt", mk_br(4'h8, 4'd3, 4'd4, 16'h0001), NOOP, 4'd3, 4'd4, 1'b1, 32'h00000004, 32'd1);
    check("perr_before", 32'(protocolError), 32'd0);

    do_branch("alur", mk_br(4'h1, 4'd1, 4'd2, 16'h0001), 32'h00123456, 4'd1, 4'd2, 1'b1, 32'h00000004, 32'd5);
    check("perr_set", 32'(protocolError), 32'd1);
    do_branch("blte", mk_br(4'h3, 4'd4, 4'd1, 16'h0004), NOOP, 4'd4, 4'd1, 1'b1, 32'h00000010, 32'd0);
    check("perr_sticky", 32'(protocolError), 32'd1);

    instruction = mk_br(4'h1, 4'd1, 4'd2, 16'h0005);
    tick();
    instruction = NOOP;
    #2 reset = 1'b1;
    #1;
    check("mid_rst.cmp", 32'(execStageCmp), 32'd0);
    check("mid_rst.imm", execStageImm, 32'd0);
    check("mid_rst.rs1", execStageRs1, 32'd0);
    check("mid_rst.rv", 32'(redirectValid), 32'd0);
    check("mid_rst.perr", 32'(protocolError), 32'd0);
    check("mid_rst.idx", 32'(rs1Idx), 32'd0);
    #1 reset = 1'b0;
    tick();
    check("aborted.rv1", 32'(redirectValid), 32'd0);
    tick();
    check("aborted.rv2", 32'(redirectValid), 32'd0);
    do_branch("post_rst", mk_br(4'h1, 4'd1, 4'd2, 16'h0003), NOOP, 4'd1, 4'd2, 1'b1, 32'h0000000C, 32'd5);
    check("post_rst.perr", 32'(protocolError), 32'd0);

    do_branch("ill4", mk_br(4'h4, 4'd1, 4'd2, 16'h0001), NOOP, 4'd1, 4'd2, 1'b0, 32'h00000004, 32'd5);
    check("ill4.perr", 32'(protocolError), 32'd1);
    do_branch("illC", mk_br(4'hC, 4'd1, 4'd2, 16'h0002), NOOP, 4'd1, 4'd2, 1'b0, 32'h00000008, 32'd5);

`ifdef BRANCH_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stats.rst_t", 32'(takenCount), 32'd0);
    check("stats.rst_n", 32'(notTakenCount), 32'd0);
    for (int i = 0; i < 3; i++)
      do_branch("st_t", mk_br(4'h1, 4'd1, 4'd2, 16'h0001), NOOP, 4'd1, 4'd2, 1'b1, 32'h00000004, 32'd5);
    for (int i = 0; i < 2; i++)
      do_branch("st_n", mk_br(4'h2, 4'd3, 4'd4, 16'h0001), NOOP, 4'd3, 4'd4, 1'b0, 32'h00000004, 32'd1);
    do_branch("st_jal", mk_jal(4'd7, 16'h0001), NOOP, 4'd7, 4'd0, 1'b1, 32'h00000004, 32'h00000100);
    check("stats.taken", 32'(takenCount), 32'd3);
    check("stats.ntaken", 32'(notTakenCount), 32'd2);
    force dut.r_taken_cnt = 16'hFFFF;
    tick();
    release dut.r_taken_cnt;
    do_branch("st_sat", mk_br(4'h1, 4'd1, 4'd2, 16'h0001), NOOP, 4'd1, 4'd2, 1'b1, 32'h00000004, 32'd5);
    check("stats.sat", 32'(takenCount), 32'h0000FFFF);
    check("stats.ntaken2", 32'(notTakenCount), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
